// File: rtl/sd_spi_shifter.sv
// ---------------------------------------------------------------------------
// sd_spi_shifter
//
// Byte-wide SPI mode-0 shifter for an SD card link. One START moves one
// byte out on SD_MOSI (MSB first) while the byte coming back on SD_MISO is
// collected. SD_CLK runs at one of two speeds, picked per transfer by FAST.
//
// Parameters
//   SLOW_HALF  SD_CLK half-period in MCLK cycles when FAST=0 (1..255)
//   FAST_HALF  SD_CLK half-period in MCLK cycles when FAST=1 (1..255)
//
// Ports
//   MCLK      in   system clock, every register updates on its rising edge
//   nRESET    in   synchronous active-low reset
//   START     in   transfer request, honoured only in IDLE
//   TX_BYTE   in   byte to send, captured at START acceptance
//   CS_LEVEL  in   SD_nCS level for this transfer, captured at acceptance
//   FAST      in   speed select, captured at acceptance
//   BUSY      out  high while a transfer is running
//   DONE      out  one-cycle completion pulse
//   RX_BYTE   out  most recently received byte
//   SD_CLK    out  SPI clock, idles low
//   SD_MOSI   out  SPI data to the card, idles high
//   SD_MISO   in   SPI data from the card
//   SD_nCS    out  chip select, held between transfers
// ---------------------------------------------------------------------------
module sd_spi_shifter #(
  parameter int SLOW_HALF = 32,
  parameter int FAST_HALF = 1
) (
  input  logic       MCLK,
  input  logic       nRESET,
  input  logic       START,
  input  logic [7:0] TX_BYTE,
  input  logic       CS_LEVEL,
  input  logic       FAST,
  output logic       BUSY,
  output logic       DONE,
  output logic [7:0] RX_BYTE,
  output logic       SD_CLK,
  output logic       SD_MOSI,
  input  logic       SD_MISO,
  output logic       SD_nCS
);

  localparam logic [7:0] SLOW_H = 8'(SLOW_HALF);
  localparam logic [7:0] FAST_H = 8'(FAST_HALF);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOW    = 2'd1,
    HIGH   = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t     state_reg, state_next;
  logic [7:0] div_reg, div_next;       // counts down the current half-period
  logic [7:0] half_reg, half_next;     // half-period captured at acceptance
  logic [7:0] tx_reg, tx_next;         // transmit byte, shifted left per bit
  logic [7:0] rx_sh_reg, rx_sh_next;   // receive shift register
  logic [7:0] rx_byte_reg, rx_byte_next;
  logic [2:0] bit_reg, bit_next;
  logic       busy_reg, busy_next;
  logic       done_reg, done_next;
  logic       sclk_reg, sclk_next;
  logic       mosi_reg, mosi_next;
  logic       ncs_reg, ncs_next;
  logic [7:0] half_sel;

  assign half_sel = FAST ? FAST_H : SLOW_H;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge MCLK) begin
    if (!nRESET) begin
      state_reg   <= IDLE;
      div_reg     <= 8'd0;
      half_reg    <= 8'd0;
      tx_reg      <= 8'd0;
      rx_sh_reg   <= 8'd0;
      rx_byte_reg <= 8'h00;
      bit_reg     <= 3'd0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      sclk_reg    <= 1'b0;
      mosi_reg    <= 1'b1;
      ncs_reg     <= 1'b1;
    end else begin
      state_reg   <= state_next;
      div_reg     <= div_next;
      half_reg    <= half_next;
      tx_reg      <= tx_next;
      rx_sh_reg   <= rx_sh_next;
      rx_byte_reg <= rx_byte_next;
      bit_reg     <= bit_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      sclk_reg    <= sclk_next;
      mosi_reg    <= mosi_next;
      ncs_reg     <= ncs_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and output logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next   = state_reg;
    div_next     = div_reg;
    half_next    = half_reg;
    tx_next      = tx_reg;
    rx_sh_next   = rx_sh_reg;
    rx_byte_next = rx_byte_reg;
    bit_next     = bit_reg;
    busy_next    = busy_reg;
    done_next    = 1'b0;
    sclk_next    = sclk_reg;
    mosi_next    = mosi_reg;
    ncs_next     = ncs_reg;

    unique case (state_reg)
      IDLE: begin
        if (START) begin
          // Everything the transfer depends on is captured here so that
          // later changes on the request inputs cannot disturb it.
          half_next  = half_sel;
          tx_next    = TX_BYTE;
          ncs_next   = CS_LEVEL;
          mosi_next  = TX_BYTE[7];
          busy_next  = 1'b1;
          bit_next   = 3'd0;
          div_next   = half_sel - 8'd1;
          sclk_next  = 1'b0;
          state_next = LOW;
        end
      end

      LOW: begin
        if (div_reg == 8'd0) begin
          // Rising SD_CLK edge: the card's bit is sampled on this same edge.
          sclk_next  = 1'b1;
          rx_sh_next = {rx_sh_reg[6:0], SD_MISO};
          div_next   = half_reg - 8'd1;
          state_next = HIGH;
        end else begin
          div_next = div_reg - 8'd1;
        end
      end

      HIGH: begin
        if (div_reg == 8'd0) begin
          sclk_next = 1'b0;
          div_next  = half_reg - 8'd1;
          if (bit_reg != 3'd7) begin
            // Falling SD_CLK edge: present the next transmit bit.
            bit_next   = bit_reg + 3'd1;
            tx_next    = {tx_reg[6:0], 1'b0};
            mosi_next  = tx_reg[6];
            state_next = LOW;
          end else begin
            state_next = FINISH;
          end
        end else begin
          div_next = div_reg - 8'd1;
        end
      end

      FINISH: begin
        // SD_nCS is deliberately left alone so the card stays selected
        // across a multi-byte command.
        rx_byte_next = rx_sh_reg;
        done_next    = 1'b1;
        busy_next    = 1'b0;
        mosi_next    = 1'b1;
        bit_next     = 3'd0;
        div_next     = 8'd0;
        state_next   = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign BUSY    = busy_reg;
  assign DONE    = done_reg;
  assign RX_BYTE = rx_byte_reg;
  assign SD_CLK  = sclk_reg;
  assign SD_MOSI = mosi_reg;
  assign SD_nCS  = ncs_reg;

endmodule

// File: doc/sd_spi_shifter.md
SD_SPI_SHIFTER -- requirements
Module: sd_spi_shifter

Interface
REQ-001 Parameter SLOW_HALF, default 32: SD_CLK half-period in MCLK cycles when FAST=0 (valid range 1..255).
REQ-002 Parameter FAST_HALF, default 1: SD_CLK half-period in MCLK cycles when FAST=1 (valid range 1..255).
REQ-003 MCLK  in  1  sole clock; all state changes on its rising edge.
REQ-004 nRESET  in  1  synchronous, active-low reset.
REQ-005 START  in  1  transfer request from the bus register block; sampled each MCLK edge.
REQ-006 TX_BYTE  in  8  byte to transmit, MSB first.
REQ-007 CS_LEVEL  in  1  level to drive on SD_nCS for this transfer.
REQ-008 FAST  in  1  1 selects FAST_HALF, 0 selects SLOW_HALF.
REQ-009 BUSY  out  1  high while a transfer is in progress.
REQ-010 DONE  out  1  one-cycle pulse on transfer completion.
REQ-011 RX_BYTE  out  8  last received byte.
REQ-012 SD_CLK  out  1  SPI clock to the card, idle low.
REQ-013 SD_MOSI  out  1  SPI data to the card, idle high.
REQ-014 SD_MISO  in  1  SPI data from the card.
REQ-015 SD_nCS  out  1  card chip select, held between transfers.

Function
REQ-016 The design SHALL use one clock (MCLK) and a synchronous, active-low reset (nRESET); there SHALL be no other clock or asynchronous reset.
REQ-017 SPI mode 0 SHALL be used: MISO sampled and SD_CLK driven high on the same edge; MOSI changes only on SD_CLK falling edges or at transfer start.
REQ-018 States SHALL be IDLE, LOW, HIGH, FINISH.
REQ-019 IDLE: on the edge where START=1, the block SHALL latch TX_BYTE, FAST and H (H = FAST ? FAST_HALF : SLOW_HALF); drive SD_nCS<=CS_LEVEL and SD_MOSI<=TX_BYTE[7]; set BUSY=1, bit counter=0, divider=H-1; and go to LOW.
REQ-020 LOW: SD_CLK=0; when the divider reaches 0, on that edge the block SHALL set SD_CLK=1, shift SD_MISO into the receive shift register LSB, reload the divider to H-1, and go to HIGH.
REQ-021 HIGH: SD_CLK=1; when the divider reaches 0, the block SHALL set SD_CLK=0 and reload the divider.
REQ-022 HIGH, continued: if the bit counter is <7, the block SHALL increment it, drive the next TX bit on SD_MOSI and go to LOW.
REQ-023 HIGH, continued: if the bit counter is 7, the block SHALL go to FINISH.
REQ-024 Each SD_CLK half-period SHALL last exactly H MCLK cycles; one byte SHALL produce exactly 8 SD_CLK high pulses.
REQ-025 FINISH (one cycle): the block SHALL copy the shift register to RX_BYTE, assert DONE for exactly one cycle, clear BUSY, set SD_MOSI=1, and return to IDLE.
REQ-026 The DONE pulse SHALL appear 16*H+1 MCLK edges after the START-accepting edge.
REQ-027 START SHALL be ignored while BUSY=1 or in FINISH; a START in the first IDLE cycle after FINISH SHALL be accepted, giving a minimum of 1 idle cycle between bytes.
REQ-028 TX_BYTE, CS_LEVEL and FAST changing mid-transfer SHALL have no effect.
REQ-029 SD_nCS SHALL change only at START acceptance or reset; it SHALL NOT change at FINISH.
REQ-030 RX_BYTE SHALL be stable except in the FINISH cycle.

Reset
REQ-031 While nRESET=0 at an MCLK edge, the block SHALL go to IDLE with SD_nCS=1, SD_CLK=0, SD_MOSI=1, BUSY=0, DONE=0, RX_BYTE=8'h00, and counters=0.
REQ-032 Reset mid-transfer SHALL abort the transfer immediately with no DONE pulse and RX_BYTE=8'h00.
REQ-033 START asserted in the same cycle as nRESET=0 SHALL be ignored.

Verification
REQ-034 Slow byte: START with TX=8'hAA, CS_LEVEL=0, FAST=0; card model returns 8'h3C -> MOSI bits 10101010; 8 SD_CLK pulses each 32 cycles high; DONE at edge 513; RX_BYTE=8'h3C; SD_nCS stays 0.
REQ-035 Fast byte: START with TX=8'h55, CS_LEVEL=1, FAST=1; card returns 8'hC3 -> SD_CLK period 2 MCLK; DONE at edge 17; RX_BYTE=8'hC3; SD_nCS=1.
REQ-036 Busy lockout: second START with TX=8'hFF issued 5 cycles into an 8'hAA transfer -> ignored; only one DONE; MOSI pattern is that of 8'hAA.
REQ-037 Back-to-back: START held high continuously with FAST=1 -> consecutive bytes with exactly one IDLE cycle between FINISH and the next SD_CLK low phase.
REQ-038 Reset abort: nRESET=0 at cycle 100 of a slow transfer -> next edge SD_nCS=1, SD_CLK=0, SD_MOSI=1, BUSY=0, RX_BYTE=8'h00; no DONE pulse.
